// File: rtl/daq_event_builder_if.sv
// Bus bundles for the DAQ event builder: 32-bit stream input and 64-bit event link output.
// Pure wiring; no latency.
// Backpressure: stream uses tvalid/tready, link uses ready/almost_full toward the producer.

interface daq_axis_if;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;

    modport master (output tvalid, output tdata, output tlast, input  tready);
    modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

interface daq_link_if;
    logic        ready;
    logic        almost_full;
    logic        valid;
    logic        header;
    logic        trailer;
    logic [63:0] data;

    modport master (input  ready, input  almost_full,
                    output valid, output header, output trailer, output data);
    modport slave  (output ready, output almost_full,
                    input  valid, input  header, input  trailer, input  data);
endinterface

// File: rtl/daq_event_builder.sv
// Frames each 32-bit stream packet as one 64-bit DAQ event: header, packed payload, trailer.
// Latency: header 1 cycle after IDLE sees a pending beat; data word 1 cycle after its completing beat.
// Backpressure: tready = go (ready & ~almost_full) in PAYLOAD; trailer waits for go. Optional BX stamp: DAQ_EVB_BX_COUNTER_EN.

module daq_event_builder #(
    parameter logic [11:0] SOURCE_ID         = 12'h000,
    parameter int          MAX_PAYLOAD_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    daq_axis_if.slave   s_axis,
    daq_link_if.master  daq,
    output logic [23:0] event_number,
    output logic        truncated
);

    localparam logic [19:0] MAX_WORDS = 20'(MAX_PAYLOAD_WORDS);

    typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_valid, r_header, r_trailer;
    logic [63:0] r_data;
    logic [23:0] r_event_number;
    logic        r_truncated;
    logic [19:0] r_wcnt;
    logic        r_half;
    logic [31:0] r_hi;
    logic        r_odd;
    logic        r_trunc_evt;

    logic        w_go, w_accept, w_sat;
    logic        w_emit_hdr, w_emit_word, w_emit_trl, w_set_odd, w_set_trunc;
    logic [63:0] w_word, w_hdr_word, w_trl_word;
    logic [11:0] w_bx;

    assign w_go            = daq.ready & ~daq.almost_full;
    assign s_axis.tready   = w_go & (r_state == PAYLOAD);
    assign w_accept        = s_axis.tvalid & s_axis.tready;
    assign w_sat           = (r_wcnt == MAX_WORDS);

`ifdef DAQ_EVB_BX_COUNTER_EN
    logic [11:0] r_bx;

    // Free-running bunch-crossing counter, one LHC orbit (3564 slots) long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_bx <= 12'd0;
        else if (r_bx == 12'd3563)  r_bx <= 12'd0;
        else                        r_bx <= r_bx + 12'd1;
    end

    assign w_bx = r_bx;
`else
    assign w_bx = 12'h000;
`endif

    assign w_hdr_word = {8'h00, r_event_number, w_bx, SOURCE_ID, 8'h00};
    // CRC field left zero; the link inserts it.
    assign w_trl_word = {32'h0, r_event_number[7:0], r_trunc_evt, r_odd, 2'b00,
                         r_wcnt + 20'd2};

    // Next state and per-cycle emit decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_emit_hdr  = 1'b0;
        w_emit_word = 1'b0;
        w_emit_trl  = 1'b0;
        w_word      = 64'h0;
        w_set_odd   = 1'b0;
        w_set_trunc = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Header only once a beat is pending, so no event is ever empty.
                if (s_axis.tvalid && w_go) begin
                    w_emit_hdr  = 1'b1;
                    w_state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_accept) begin
                    if (w_sat) begin
                        // Beat still consumed so the sender drains, but its data is dropped.
                        w_set_trunc = 1'b1;
                    end else if (r_half) begin
                        w_emit_word = 1'b1;
                        w_word      = {r_hi, s_axis.tdata};
                    end else if (s_axis.tlast) begin
                        w_emit_word = 1'b1;
                        w_word      = {s_axis.tdata, 32'h0};
                        w_set_odd   = 1'b1;
                    end
                    if (s_axis.tlast) w_state_nxt = TRAILER;
                end
            end
            TRAILER: begin
                if (w_go) begin
                    w_emit_trl  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Output word register, pack buffer, counters and status bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid        <= 1'b0;
            r_header       <= 1'b0;
            r_trailer      <= 1'b0;
            r_data         <= 64'h0;
            r_event_number <= 24'h000001;
            r_truncated    <= 1'b0;
            r_wcnt         <= 20'd0;
            r_half         <= 1'b0;
            r_hi           <= 32'h0;
            r_odd          <= 1'b0;
            r_trunc_evt    <= 1'b0;
        end else begin
            r_valid   <= w_emit_hdr | w_emit_word | w_emit_trl;
            r_header  <= w_emit_hdr;
            r_trailer <= w_emit_trl;
            if (w_emit_hdr)       r_data <= w_hdr_word;
            else if (w_emit_word) r_data <= w_word;
            else if (w_emit_trl)  r_data <= w_trl_word;

            // Pairing continues through discarded beats; tlast always closes the pair.
            if (w_accept) begin
                r_half <= ~r_half & ~s_axis.tlast;
                if (!r_half) r_hi <= s_axis.tdata;
            end
            if (w_emit_word) r_wcnt <= r_wcnt + 20'd1;
            if (w_set_odd)   r_odd  <= 1'b1;
            if (w_set_trunc) begin
                r_trunc_evt <= 1'b1;
                r_truncated <= 1'b1;
            end
            if (w_emit_trl) begin
                r_event_number <= r_event_number + 24'd1;
                r_wcnt         <= 20'd0;
                r_odd          <= 1'b0;
                r_trunc_evt    <= 1'b0;
                r_half         <= 1'b0;
            end
        end
    end

    assign daq.valid    = r_valid;
    assign daq.header   = r_header;
    assign daq.trailer  = r_trailer;
    assign daq.data     = r_data;
    assign event_number = r_event_number;
    assign truncated    = r_truncated;

endmodule

// File: tb/tb_daq_event_builder.sv
// Self-checking bench for daq_event_builder against a per-event framing model.
// Drives stream beats and link throttling from one directed/random sequence.
// Checks tready every cycle, every emitted word, event_number and truncated.

module tb_daq_event_builder;
    localparam logic [11:0] SRC  = 12'hABC;
    localparam int          MAXW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    daq_axis_if axis ();
    daq_link_if link ();
    logic [23:0] event_number;
    logic        truncated;

    daq_event_builder #(.SOURCE_ID(SRC), .MAX_PAYLOAD_WORDS(MAXW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis       (axis),
        .daq          (link),
        .event_number (event_number),
        .truncated    (truncated)
    );

    typedef struct packed {
        logic        h;
        logic        t;
        logic [63:0] d;
    } word_t;

    int          checks = 0;
    int          errors = 0;
    word_t       q[$];
    int          hdr_cnt = 0;
    int          trl_cnt = 0;
    int          trl_seen = 0;
    int          trl_stp = 0;
    int          cyc = 0;
    logic [11:0] hdr_bx = 12'h0;
    int          stp = 0;
    int          af_lo = 0, af_hi = 0;
    bit          rnd_link = 0;
    bit          go_cur = 1'b1;
    logic [31:0] pkt[$];
    logic [23:0] exp_evn = 24'h000001;
    bit          trunc_sticky = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Cycles since reset release, used to predict the BX stamp.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Collect every emitted link word, sampled just after the clock edge.
    always @(posedge clk) begin
        #1;
        if (link.valid === 1'b1) begin
            q.push_back('{h: link.header, t: link.trailer, d: link.data});
            if (link.header) begin
                hdr_cnt++;
`ifdef DAQ_EVB_BX_COUNTER_EN
                hdr_bx = 12'((cyc - 1) % 3564);
`else
                hdr_bx = 12'h000;
`endif
            end
            if (link.trailer) trl_cnt++;
        end
    end

    // One cycle: check trailer gating for the previous edge, then drive link throttle.
    task automatic step();
        bit af, rdy;
        @(negedge clk);
        if (trl_cnt != trl_seen) begin
            chk("trailer_only_when_go", go_cur, 1);
            trl_seen = trl_cnt;
            trl_stp  = stp;
        end
        stp++;
        af  = (stp >= af_lo && stp < af_hi) || (rnd_link && $urandom_range(0, 3) == 0);
        rdy = rnd_link ? ($urandom_range(0, 7) != 0) : 1'b1;
        link.ready       = rdy;
        link.almost_full = af;
        go_cur           = rdy & ~af;
    endtask

    // Present pkt[0..n-1]; tlast on the final beat when use_last is set.
    task automatic send_pkt(input int n, input int gap_pct, input bit use_last);
        int i = 0;
        int budget = 0;
        int hdr0 = hdr_cnt;
        bit vld;
        while (i < n && budget < 2000) begin
            step();
            budget++;
            vld = ($urandom_range(0, 99) >= gap_pct);
            axis.tvalid = vld;
            axis.tdata  = pkt[i];
            axis.tlast  = use_last && (i == n - 1);
            #1;
            chk("tready", axis.tready, go_cur && (hdr_cnt > hdr0));
            if (vld && axis.tready) i++;
        end
        chk("beats_accepted", i, n);
        @(posedge clk);
        #1;
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
    endtask

    task automatic wait_trailer();
        int b = 0;
        int t0 = trl_cnt;
        while (trl_cnt == t0 && b < 300) begin
            step();
            b++;
        end
        chk("trailer_seen", trl_cnt, t0 + 1);
    endtask

    // Compare the queued words of one event against the framing rules.
    task automatic check_event(input int n);
        int    nw = (n + 1) / 2;
        int    ne = (nw < MAXW) ? nw : MAXW;
        bit    tr = (n > 2 * MAXW);
        bit    od = (n % 2 == 1);
        word_t w;
        logic [31:0] lo;
        chk("event_word_count", q.size(), ne + 2);
        if (q.size() > 0) begin
            w = q.pop_front();
            chk("hdr_flags", {w.h, w.t}, 2'b10);
            chk("hdr_word", w.d, {8'h00, exp_evn, hdr_bx, SRC, 8'h00});
        end
        for (int k = 0; k < ne; k++) begin
            if (q.size() > 0) begin
                w  = q.pop_front();
                lo = (2 * k + 1 < n) ? pkt[2 * k + 1] : 32'h0;
                chk("data_flags", {w.h, w.t}, 2'b00);
                chk("data_word", w.d, {pkt[2 * k], lo});
            end
        end
        if (q.size() > 0) begin
            w = q.pop_front();
            chk("trl_flags", {w.h, w.t}, 2'b01);
            chk("trl_word", w.d, {32'h0, exp_evn[7:0], tr, od, 2'b00, 20'(ne + 2)});
        end
        q.delete();
        exp_evn      = exp_evn + 24'd1;
        trunc_sticky = trunc_sticky | tr;
        chk("event_number", event_number, exp_evn);
        chk("truncated", truncated, trunc_sticky);
    endtask

    task automatic run_event(input int n, input int gap_pct);
        send_pkt(n, gap_pct, 1'b1);
        wait_trailer();
        check_event(n);
    endtask

    task automatic fill_rand(input int n);
        pkt.delete();
        for (int k = 0; k < n; k++) pkt.push_back($urandom());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        axis.tvalid      = 1'b0;
        axis.tdata       = 32'h0;
        axis.tlast       = 1'b0;
        link.ready       = 1'b1;
        link.almost_full = 1'b0;
        repeat (3) step();
        chk("rst_valid", link.valid, 0);
        chk("rst_header", link.header, 0);
        chk("rst_trailer", link.trailer, 0);
        chk("rst_data", link.data, 64'h0);
        chk("rst_tready", axis.tready, 0);
        chk("rst_event_number", event_number, 24'h000001);
        chk("rst_truncated", truncated, 0);
        rst_n = 1'b1;
        step();

        // Single 4-beat event.
        pkt = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_event(4, 0);

        // Odd packet: last word padded with zeros.
        pkt = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
        run_event(3, 0);

        // Almost-full window mid-payload; tready must drop in exactly those cycles.
        fill_rand(8);
        af_lo = stp + 4;
        af_hi = af_lo + 5;
        run_event(8, 0);

        // Almost-full right after tlast: trailer must wait for the window to close.
        fill_rand(2);
        af_lo = stp + 4;
        af_hi = af_lo + 5;
        send_pkt(2, 0, 1'b1);
        wait_trailer();
        chk("trailer_held", trl_stp, af_hi);
        check_event(2);
        af_lo = 0;
        af_hi = 0;

        // Truncation: 12 beats into a 4-word limit.
        fill_rand(12);
        run_event(12, 0);
        pkt = '{32'h01020304, 32'h05060708};
        run_event(2, 0);

        // Random lengths, random gaps and link throttling.
        rnd_link = 1;
        for (int e = 0; e < 20; e++) begin
            n = ($urandom_range(0, 3) == 0) ? 2 * $urandom_range(5, 8) : $urandom_range(1, 8);
            fill_rand(n);
            run_event(n, 30);
        end
        rnd_link = 0;

        // Event number wrap.
        step();
        force dut.r_event_number = 24'hFFFFFF;
        step();
        release dut.r_event_number;
        step();
        exp_evn = 24'hFFFFFF;
        chk("preload_event_number", event_number, 24'hFFFFFF);
        fill_rand(2);
        run_event(2, 0);
        chk("wrapped_to_zero", event_number, 24'h000000);

        // Reset in the middle of a payload.
        fill_rand(3);
        send_pkt(3, 0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", link.valid, 0);
        chk("midrst_header", link.header, 0);
        chk("midrst_trailer", link.trailer, 0);
        chk("midrst_data", link.data, 64'h0);
        chk("midrst_tready", axis.tready, 0);
        chk("midrst_event_number", event_number, 24'h000001);
        chk("midrst_truncated", truncated, 0);
        step();
        step();
        q.delete();
        trl_seen     = trl_cnt;
        exp_evn      = 24'h000001;
        trunc_sticky = 0;
        rst_n        = 1'b1;
        step();
        fill_rand(5);
        run_event(5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
